// File: rtl/mult_sequencer.sv
// Shift-and-add multiplier sequencer driving external A (left-shift) and B (right-shift) registers.
// Define MULT_SEQUENCER_SIGNED_EN for two's-complement operands; the default build is unsigned.
module mult_sequencer #(
    parameter int WORD_LENGTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [WORD_LENGTH-1:0]     multiplicand,
    input  logic [WORD_LENGTH-1:0]     multiplier,
    input  logic                       mplier_lsb,
    input  logic [2*WORD_LENGTH-1:0]   mcand_shifted,
    output logic                       sr_load,
    output logic                       sr_shift,
    output logic [WORD_LENGTH-1:0]     mplier_load_value,
    output logic [2*WORD_LENGTH-1:0]   mcand_load_value,
    output logic [2*WORD_LENGTH-1:0]   product,
    output logic                       busy,
    output logic                       done
);

    localparam int W     = WORD_LENGTH;
    localparam int PW    = 2 * WORD_LENGTH;
    localparam int CNT_W = (WORD_LENGTH > 1) ? $clog2(WORD_LENGTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_LENGTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]      acc_q, acc_d;
    logic [PW-1:0]      product_q, product_d;
    logic [W-1:0]       mcand_lv_q, mcand_lv_d;
    logic [W-1:0]       mplier_lv_q, mplier_lv_d;
    logic               neg_q, neg_d;
    logic               sr_load_q, sr_load_d;
    logic               sr_shift_q, sr_shift_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

`ifdef MULT_SEQUENCER_SIGNED_EN
    // Magnitude of a two's-complement operand; the most negative value maps onto 2^(W-1).
    function automatic logic [W-1:0] abs_val(input logic [W-1:0] v);
        logic [W-1:0] r;
        if (v[W-1]) begin
            r = (~v) + W'(1);
        end else begin
            r = v;
        end
        return r;
    endfunction
`endif

    // Product sign correction applied to the magnitude accumulated by the shift-and-add loop.
    function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] mag, input logic neg);
        logic [PW-1:0] r;
        if (neg) begin
            r = (~mag) + PW'(1);
        end else begin
            r = mag;
        end
        return r;
    endfunction

    // Next-state, datapath and next-output computation.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        acc_d       = acc_q;
        product_d   = product_q;
        mcand_lv_d  = mcand_lv_q;
        mplier_lv_d = mplier_lv_q;
        neg_d       = neg_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD;
`ifdef MULT_SEQUENCER_SIGNED_EN
                    mcand_lv_d  = abs_val(multiplicand);
                    mplier_lv_d = abs_val(multiplier);
                    neg_d       = multiplicand[W-1] ^ multiplier[W-1];
`else
                    mcand_lv_d  = multiplicand;
                    mplier_lv_d = multiplier;
                    neg_d       = 1'b0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                state_d = ST_RUN;
                cnt_d   = {CNT_W{1'b0}};
                acc_d   = {PW{1'b0}};
            end
            ST_RUN: begin
                if (mplier_lsb) begin
                    acc_d = acc_q + mcand_shifted;
                end else begin
                    acc_d = acc_q;
                end
                cnt_d = cnt_q + CNT_W'(1);
                // The final product includes this cycle's partial product.
                if (cnt_q == LAST_BIT) begin
                    state_d   = ST_DONE;
                    product_d = apply_sign(acc_d, neg_q);
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        sr_load_d  = (state_d == ST_LOAD);
        sr_shift_d = (state_d == ST_RUN);
        busy_d     = (state_d != ST_IDLE);
        // done trails the DONE state by one cycle so it lands W+2 edges after start.
        done_d     = (state_q == ST_DONE);
    end

    // State, datapath and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            acc_q       <= {PW{1'b0}};
            product_q   <= {PW{1'b0}};
            mcand_lv_q  <= {W{1'b0}};
            mplier_lv_q <= {W{1'b0}};
            neg_q       <= 1'b0;
            sr_load_q   <= 1'b0;
            sr_shift_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            acc_q       <= acc_d;
            product_q   <= product_d;
            mcand_lv_q  <= mcand_lv_d;
            mplier_lv_q <= mplier_lv_d;
            neg_q       <= neg_d;
            sr_load_q   <= sr_load_d;
            sr_shift_q  <= sr_shift_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign sr_load           = sr_load_q;
    assign sr_shift          = sr_shift_q;
    assign mplier_load_value = mplier_lv_q;
    assign mcand_load_value  = {{W{1'b0}}, mcand_lv_q};
    assign product           = product_q;
    assign busy              = busy_q;
    assign done              = done_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboard bench for mult_sequencer (W=4) with behavioural external shift registers.
module tb_mult_sequencer;

    localparam int W  = 4;
    localparam int PW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [W-1:0]  multiplicand = '0;
    logic [W-1:0]  multiplier = '0;
    logic          mplier_lsb;
    logic [PW-1:0] mcand_shifted;
    logic          sr_load, sr_shift;
    logic [W-1:0]  mplier_load_value;
    logic [PW-1:0] mcand_load_value;
    logic [PW-1:0] product;
    logic          busy, done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic done_prev = 1'b0;

    logic [PW-1:0] exp_q[$];
    int            exp_cyc_q[$];

    logic [W-1:0]  b_sr;
    logic [PW-1:0] a_sr;

    mult_sequencer #(.WORD_LENGTH(W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .mplier_lsb(mplier_lsb), .mcand_shifted(mcand_shifted),
        .sr_load(sr_load), .sr_shift(sr_shift),
        .mplier_load_value(mplier_load_value), .mcand_load_value(mcand_load_value),
        .product(product), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // External right-shift (B) and left-shift (A) registers.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            b_sr <= '0;
            a_sr <= '0;
        end else if (sr_load) begin
            b_sr <= mplier_load_value;
            a_sr <= mcand_load_value;
        end else if (sr_shift) begin
            b_sr <= b_sr >> 1;
            a_sr <= a_sr << 1;
        end
    end
    assign mplier_lsb    = b_sr[0];
    assign mcand_shifted = a_sr;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] model_prod(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [PW-1:0] r;
`ifdef MULT_SEQUENCER_SIGNED_EN
        int sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        r  = PW'(sa * sb);
`else
        r = PW'({4'b0, a} * {4'b0, b});
`endif
        return r;
    endfunction

    // Output monitor: protocol checks every cycle, scoreboard pop on done.
    always @(posedge clk) begin
        #1;
        check_val("sr_exclusive", {31'b0, sr_load & sr_shift}, 32'd0);
        check_val("done_width", {31'b0, done & done_prev}, 32'd0);
        if (done) begin
            if (exp_q.size() == 0) begin
                check_val("spurious_done", 32'd1, 32'd0);
            end else begin
                check_val("product", {24'b0, product}, {24'b0, exp_q.pop_front()});
                check_val("done_latency", cyc, exp_cyc_q.pop_front());
            end
        end
        done_prev = done;
    end

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b);
        int c0;
        @(negedge clk);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        start = 1'b0;
        exp_q.push_back(model_prod(a, b));
        exp_cyc_q.push_back(c0 + W + 2);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (2) @(posedge clk);
        #2;
        check_val("drain", exp_q.size(), 32'd0);
        exp_q.delete();
        exp_cyc_q.delete();
    endtask

    logic [W-1:0] vec_a[7] = '{4'd7, 4'd15, 4'd0, 4'd9, 4'd13, 4'd8, 4'd8};
    logic [W-1:0] vec_b[7] = '{4'd5, 4'd15, 4'd9, 4'd0, 4'd5,  4'd8, 4'd1};

    initial begin
        int c0;
        #12;
        check_val("rst_busy", {31'b0, busy}, 32'd0);
        check_val("rst_product", {24'b0, product}, 32'd0);
        check_val("rst_sr", {30'b0, sr_load, sr_shift}, 32'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            do_op(vec_a[i], vec_b[i]);
            wait_drain();
        end
        for (int i = 0; i < 4; i++) begin
            do_op(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)));
            wait_drain();
        end

        // Start re-pulsed during RUN must be ignored.
        do_op(4'd7, 4'd5);
        repeat (2) @(negedge clk);
        multiplicand = 4'd3;
        multiplier   = 4'd3;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_drain();

        // Start held high: second operation accepted one IDLE cycle after DONE.
        @(negedge clk);
        multiplicand = 4'd2;
        multiplier   = 4'd7;
        start        = 1'b1;
        @(posedge clk);
        #1;
        c0 = cyc;
        exp_q.push_back(model_prod(4'd2, 4'd7));
        exp_cyc_q.push_back(c0 + W + 2);
        exp_q.push_back(model_prod(4'd2, 4'd7));
        exp_cyc_q.push_back(c0 + 2 * W + 5);
        repeat (W + 3) @(posedge clk);
        #1;
        start = 1'b0;
        wait_drain();

        // Asynchronous reset during the second RUN cycle.
        @(negedge clk);
        multiplicand = 4'd7;
        multiplier   = 4'd5;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_val("midrun_busy", {31'b0, busy}, 32'd0);
        check_val("midrun_product", {24'b0, product}, 32'd0);
        check_val("midrun_shift", {31'b0, sr_shift}, 32'd0);
        check_val("midrun_done", {31'b0, done}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        do_op(4'd2, 4'd3);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mult_sequencer.md
MULT_SEQUENCER -- requirements
Module: mult_sequencer

Interface
REQ-001 Parameter WORD_LENGTH, default 4, SHALL set the operand width W; product width is 2W.
REQ-002 clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-003 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 start  input  1  SHALL request a multiplication; sampled only in IDLE.
REQ-005 multiplicand  input  W  SHALL be operand A, captured on the edge that accepts start.
REQ-006 multiplier  input  W  SHALL be operand B, captured on the edge that accepts start.
REQ-007 mplier_lsb  input  1  SHALL be the serial output (bit 0) of the external right-shift register holding B.
REQ-008 mcand_shifted  input  2W  SHALL be the parallel output of the external left-shift register holding A.
REQ-009 sr_load  output  1  SHALL drive the load input of both external shift registers.
REQ-010 sr_shift  output  1  SHALL drive the shift input of both external shift registers.
REQ-011 mplier_load_value  output  W  SHALL be the parallel load value for the B register.
REQ-012 mcand_load_value  output  2W  SHALL be the parallel load value for the A register, zero-extended.
REQ-013 product  output  2W  SHALL be the registered result.
REQ-014 busy  output  1  SHALL be high in every state except IDLE.
REQ-015 done  output  1  SHALL pulse high for exactly one cycle when product is valid.

Function
REQ-016 FSM SHALL have states IDLE, LOAD, RUN, DONE; IDLE->LOAD when start=1, LOAD->RUN unconditionally, RUN->DONE when bit counter = W-1, DONE->IDLE unconditionally.
REQ-017 In LOAD, sr_load SHALL be 1, sr_shift 0, the accumulator SHALL clear to 0, and the bit counter SHALL clear to 0.
REQ-018 In RUN, each cycle: sr_shift=1; accumulator SHALL add mcand_shifted when mplier_lsb=1 (sum modulo 2^2W); counter SHALL increment.
REQ-019 On the RUN->DONE edge, product SHALL take the final accumulator value (including the last RUN addition).
REQ-020 sr_load and sr_shift SHALL never be high in the same cycle; both SHALL be 0 in IDLE and DONE.
REQ-021 done SHALL rise W+2 rising edges after the edge that samples start=1 in IDLE.
REQ-022 start while busy=1 SHALL be ignored, with no effect on operands or state.
REQ-023 start=1 held continuously SHALL begin a new operation on the edge leaving DONE->IDLE plus one (IDLE is always visited for one cycle).
REQ-024 product SHALL hold its value from DONE until the next RUN->DONE transition.

Reset
REQ-025 reset=0 SHALL force state IDLE, counter 0, accumulator 0, product 0, captured operands 0, busy 0, done 0, sr_load 0, sr_shift 0, asynchronously, including mid-RUN.
REQ-026 After reset release, the block SHALL accept start on the first rising edge.

Configuration
REQ-027 With macro MULT_SEQUENCER_SIGNED_EN defined, operands SHALL be two's complement: load values SHALL be absolute values (-2^(W-1) loads as 2^(W-1)), and product SHALL be the two's-complement negation of the accumulator when operand signs differ.
REQ-028 Without MULT_SEQUENCER_SIGNED_EN, operands and product SHALL be unsigned, and load values SHALL equal the captured operands.

Verification (W=4, bench wires the team's right- and left-shift registers to the sr_* ports)
REQ-029 Unsigned: A=7, B=5, start pulse -> done exactly 6 edges later, product=0x23; A=15, B=15 -> product=0xE1.
REQ-030 Zero: A=0, B=9 -> product=0x00, done after 6 edges; A=9, B=0 -> product=0x00.
REQ-031 Busy: start re-pulsed with A=3, B=3 during RUN of 7x5 -> ignored, product=0x23, single done pulse.
REQ-032 Reset mid-RUN: reset=0 during second RUN cycle -> immediately busy=0, product=0, sr_shift=0; subsequent 2x3 -> product=0x06.
REQ-033 Signed (MULT_SEQUENCER_SIGNED_EN): A=-3, B=5 -> product=0xF1; A=-8, B=-8 -> product=0x40; A=-8, B=1 -> product=0xF8.
REQ-034 Protocol check on every test: sr_load and sr_shift never both 1; done high exactly one cycle per accepted start.
